uart_rx_fifo: RTL and testbench

- Receive-side buffer placed directly downstream of the UART receiver.
- Captures each single-cycle receiver pulse (rx_valid data byte or rx_error event) as one entry: the data plus an error flag.
- Presents entries to the bus/CPU side through a first-word-fall-through valid/ready port.
- Provides occupancy, almost-full, sticky overrun and saturating error/drop counters for status registers.

---
 rtl/uart_rx_fifo_pkg.sv | 26 ++
 rtl/uart_rx_fifo_if.sv | 20 ++
 rtl/uart_fifo_ram.sv | 32 +++
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared UART definitions used by the receive FIFO and its neighbours:
//   - parity mode encodings
//   - the FIFO entry layout {err, data}
//   - the width and ceiling of the saturating status counters
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_mode_e;

    localparam int UART_DATA_BITS = 8;

    typedef struct packed {
        logic                      err;
        logic [UART_DATA_BITS-1:0] data;
    } uart_entry_t;

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// First-word-fall-through valid/ready stream carrying one received entry.
//   m_data  : head entry character
//   m_err   : head entry error flag
//   m_valid : head entry present
//   m_ready : consumer accepts the head entry
// Modports: master (FIFO side), slave (consumer side).
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] m_data;
    logic                 m_err;
    logic                 m_valid;
    logic                 m_ready;

    modport master (output m_data, output m_err, output m_valid, input m_ready);
    modport slave  (input m_data, input m_err, input m_valid, output m_ready);
endinterface

// File: rtl/uart_fifo_ram.sv
// -----------------------------------------------------------------------------
// uart_fifo_ram
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module uart_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART receiver. Each rx_valid / rx_error pulse
// becomes one {err, data} entry, presented first-word-fall-through on m_if.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_data, rx_valid,
//   rx_error              : receiver character and one-cycle pulses
//   m_if (master)         : m_data / m_err / m_valid / m_ready head port
//   flush                 : synchronous clear of queue contents
//   clr_status            : clears overrun, err_count, drop_count
//   level, empty, full,
//   almost_full           : occupancy and flags from the registered level
//   overrun               : sticky, a push was lost to a full queue
//   err_count, drop_count : saturating event counters
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 16,
    parameter int AF_THRESH    = 12,
    parameter int STORE_ERRORS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_BITS-1:0]     rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_error,
    uart_rx_fifo_if.master           m_if,
    input  logic                     flush,
    input  logic                     clr_status,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overrun,
    output logic [CNT_W-1:0]         err_count,
    output logic [CNT_W-1:0]         drop_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_THRESH);
    localparam logic             STORE_EN = (STORE_ERRORS != 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // Pointers carry one extra wrap bit; they wrap modulo 2*DEPTH.
    logic [LVL_W-1:0]   wr_ptr, rd_ptr;
    logic [DATA_BITS:0] rd_entry;
    logic               push_req, push_ok, pop, lost;

    assign empty       = (level == '0);
    assign full        = (level == DEPTH_L);
    assign almost_full = (level >= AF_L);

    assign m_if.m_valid = !empty;
    // Zero while nothing is held, so outputs read 0 straight out of reset
    // even though storage is never cleared.
    assign m_if.m_data  = m_if.m_valid ? rd_entry[DATA_BITS-1:0] : '0;
    assign m_if.m_err   = m_if.m_valid ? rd_entry[DATA_BITS] : 1'b0;

    assign push_req = rx_valid | (rx_error & STORE_EN);
    assign pop      = m_if.m_valid & m_if.m_ready;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok  = push_req & (!full | pop);
    assign lost     = push_req & full & !pop;

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS + 1)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok & !flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({rx_error, rx_data}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + LVL_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LVL_W'(1);
            end
            if (push_ok && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push_ok) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Status is untouched by flush; a same-cycle event beats clr_status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun    <= 1'b0;
            err_count  <= '0;
            drop_count <= '0;
        end else if (clr_status) begin
            overrun    <= lost;
            err_count  <= rx_error ? CNT_W'(1) : '0;
            drop_count <= lost ? CNT_W'(1) : '0;
        end else begin
            if (lost) begin
                overrun    <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
            if (rx_error) begin
                err_count <= sat_inc(err_count);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo. Stimulus pushes the expected entries into
// a scoreboard queue; a monitor on the falling edge pops and compares every
// entry the DUT hands over. A second instance with STORE_ERRORS=0 shares the
// inputs to cover count-only error handling.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid, rx_error, flush, clr_status;

    logic [4:0] level, level_b;
    logic       empty, full, almost_full, overrun;
    logic       empty_b, full_b, almost_full_b, overrun_b;
    logic [7:0] err_count, drop_count, err_count_b, drop_count_b;

    uart_rx_fifo_if #(.DATA_BITS(8)) m_if ();
    uart_rx_fifo_if #(.DATA_BITS(8)) m0_if ();
    assign m0_if.m_ready = m_if.m_ready;

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .AF_THRESH(12), .STORE_ERRORS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .m_if(m_if), .flush(flush), .clr_status(clr_status),
        .level(level), .empty(empty), .full(full), .almost_full(almost_full),
        .overrun(overrun), .err_count(err_count), .drop_count(drop_count)
    );

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .AF_THRESH(12), .STORE_ERRORS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .m_if(m0_if), .flush(flush), .clr_status(clr_status),
        .level(level_b), .empty(empty_b), .full(full_b), .almost_full(almost_full_b),
        .overrun(overrun_b), .err_count(err_count_b), .drop_count(drop_count_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    uart_entry_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic e, input logic [7:0] d);
        rx_valid = v;
        rx_error = e;
        rx_data  = d;
    endtask

    task automatic idle();
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic expect_entry(input logic e, input logic [7:0] d);
        uart_entry_t x;
        x.err  = e;
        x.data = d;
        sb.push_back(x);
    endtask

    // Monitor: an entry leaves whenever valid and ready meet at the next edge,
    // unless flush discards that pop.
    always @(negedge clk) begin
        if (rst_n && m_if.m_valid && m_if.m_ready && !flush) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", int'(m_if.m_data), -1);
            end else begin
                uart_entry_t e;
                e = sb.pop_front();
                chk("pop_data", int'(m_if.m_data), int'(e.data));
                chk("pop_err", int'(m_if.m_err), int'(e.err));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        flush = 1'b0;
        clr_status = 1'b0;
        m_if.m_ready = 1'b0;
        #12;
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_mvalid", int'(m_if.m_valid), 0);
        chk("rst_mdata", int'(m_if.m_data), 0);
        chk("rst_merr", int'(m_if.m_err), 0);
        chk("rst_b_level", int'(level_b), 0);
        chk("rst_b_flags", int'({empty_b, full_b, almost_full_b, overrun_b}), 4'b1000);
        chk("rst_b_drop", int'(drop_count_b), 0);
        chk("rst_b_m", int'({m0_if.m_valid, m0_if.m_err, m0_if.m_data}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three characters streamed straight through with m_ready high.
        m_if.m_ready = 1'b1;
        drive(1, 0, 8'h41); expect_entry(0, 8'h41);
        chk("no_bypass", int'(m_if.m_valid), 0);
        tick();
        chk("first_mvalid", int'(m_if.m_valid), 1);
        drive(1, 0, 8'h42); expect_entry(0, 8'h42);
        tick();
        drive(1, 0, 8'h43); expect_entry(0, 8'h43);
        tick();
        idle();
        tick();
        chk("stream_level", int'(level), 0);
        chk("stream_empty", int'(empty), 1);

        // Fill to almost_full, full, then one lost push.
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 8'(8'h10 + i)); expect_entry(0, 8'(8'h10 + i));
            tick();
            if (i == 10) chk("af_at_11", int'(almost_full), 0);
        end
        idle();
        chk("level_12", int'(level), 12);
        chk("af_at_12", int'(almost_full), 1);
        chk("not_full_12", int'(full), 0);
        for (int i = 12; i < 16; i++) begin
            drive(1, 0, 8'(8'h10 + i)); expect_entry(0, 8'(8'h10 + i));
            tick();
        end
        idle();
        chk("full_16", int'(full), 1);
        chk("level_16", int'(level), 16);
        drive(1, 0, 8'h20);
        tick();
        idle();
        chk("ovr_set", int'(overrun), 1);
        chk("drop_1", int'(drop_count), 1);
        chk("level_after_drop", int'(level), 16);
        chk("head_kept", int'(m_if.m_data), 8'h10);

        // Clear status, then push into a full queue while the head leaves.
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_ovr", int'(overrun), 0);
        chk("clr_drop", int'(drop_count), 0);
        drive(1, 0, 8'h55); expect_entry(0, 8'h55);
        m_if.m_ready = 1'b1;
        tick();
        idle();
        m_if.m_ready = 1'b0;
        chk("swap_level", int'(level), 16);
        chk("swap_ovr", int'(overrun), 0);
        chk("swap_full", int'(full), 1);
        m_if.m_ready = 1'b1;
        repeat (16) tick();
        m_if.m_ready = 1'b0;
        chk("drain_level", int'(level), 0);
        chk("drain_sb", sb.size(), 0);

        // Error events: queued on dut, counted only on dut0.
        drive(0, 1, 8'h7E); expect_entry(1, 8'h7E);
        tick();
        idle();
        chk("err_cnt", int'(err_count), 1);
        chk("err_level", int'(level), 1);
        chk("err_head", int'({m_if.m_err, m_if.m_data}), 9'h17E);
        chk("b_err_cnt", int'(err_count_b), 1);
        chk("b_err_empty", int'(empty_b), 1);
        drive(1, 1, 8'h33); expect_entry(1, 8'h33);
        tick();
        idle();
        chk("both_err_cnt", int'(err_count), 2);
        chk("both_level", int'(level), 2);
        chk("b_both_level", int'(level_b), 1);
        m_if.m_ready = 1'b1;
        repeat (2) tick();
        m_if.m_ready = 1'b0;
        chk("err_drain", int'(level), 0);
        chk("b_err_drain", int'(level_b), 0);

        // Flush wins over a same-cycle push and pop.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 8'(8'h60 + i)); expect_entry(0, 8'(8'h60 + i));
            tick();
        end
        idle();
        chk("pre_flush_level", int'(level), 5);
        drive(1, 0, 8'h70);
        m_if.m_ready = 1'b1;
        flush = 1'b1;
        sb.delete();
        tick();
        flush = 1'b0;
        idle();
        m_if.m_ready = 1'b0;
        chk("flush_level", int'(level), 0);
        chk("flush_mvalid", int'(m_if.m_valid), 0);
        chk("flush_errcnt", int'(err_count), 2);
        chk("flush_drop", int'(drop_count), 0);
        clr_status = 1'b1;
        drive(0, 1, 8'h11); expect_entry(1, 8'h11);
        tick();
        clr_status = 1'b0;
        idle();
        chk("clr_vs_err", int'(err_count), 1);
        chk("clr_vs_err_b", int'(err_count_b), 1);
        m_if.m_ready = 1'b1;
        tick();
        m_if.m_ready = 1'b0;
        chk("post_clr_level", int'(level), 0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 8'(8'h80 + i)); expect_entry(0, 8'(8'h80 + i));
            tick();
        end
        drive(1, 0, 8'h9F);
        tick();
        idle();
        chk("burst_ovr", int'(overrun), 1);
        m_if.m_ready = 1'b1;
        repeat (9) tick();
        m_if.m_ready = 1'b0;
        chk("burst_level", int'(level), 7);
        drive(1, 0, 8'hEE);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        idle();
        chk("arst_level", int'(level), 0);
        chk("arst_ovr", int'(overrun), 0);
        chk("arst_err", int'(err_count), 0);
        chk("arst_drop", int'(drop_count), 0);
        chk("arst_mvalid", int'(m_if.m_valid), 0);
        chk("arst_mdata", int'(m_if.m_data), 0);
        chk("arst_empty", int'(empty), 1);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1, 0, 8'hA5); expect_entry(0, 8'hA5);
        m_if.m_ready = 1'b1;
        tick();
        idle();
        chk("post_rst_head", int'(m_if.m_data), 8'hA5);
        tick();
        m_if.m_ready = 1'b0;
        chk("final_level", int'(level), 0);
        chk("final_sb", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
